// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war referee and its playfield interface.
package tug_pkg;

  localparam int unsigned SCORE_W = 3;

  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t CLEAR = 3'd1;
  localparam state_t PLAY  = 3'd2;
  localparam state_t HOLD  = 3'd3;
  localparam state_t OVER  = 3'd4;

  typedef logic [1:0] winner_t;
  localparam winner_t WIN_NONE  = 2'b00;
  localparam winner_t WIN_LEFT  = 2'b01;
  localparam winner_t WIN_RIGHT = 2'b10;

endpackage

// File: rtl/tug_referee_if.sv
// Board-side bundle of the referee: keys/start/edge lights in, pulses, scores and status out.
interface tug_referee_if;
  import tug_pkg::*;

  logic               key_l;
  logic               key_r;
  logic               start;
  logic               edge_l;
  logic               edge_r;
  logic [2:0]         difficulty;
  logic               pulse_l;
  logic               pulse_r;
  logic               field_reset;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  winner_t            winner;
  logic               game_over;

  modport master (
    output key_l, key_r, start, edge_l, edge_r, difficulty,
    input  pulse_l, pulse_r, field_reset, score_l, score_r, winner, game_over
  );

  modport slave (
    input  key_l, key_r, start, edge_l, edge_r, difficulty,
    output pulse_l, pulse_r, field_reset, score_l, score_r, winner, game_over
  );

endinterface

// File: rtl/lfsr10.sv
// 10-bit XNOR LFSR (taps 10,7); the all-zero reset state is legal for the XNOR form.
module lfsr10 (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      q <= {q[8:0], ~(q[9] ^ q[6])};
    end
  end

endmodule

// File: rtl/tug_referee.sv
// Round/match controller for the tug-of-war playfield.
// Define CPU_PLAYER_EN to replace the right key with an LFSR-driven computer player.
module tug_referee
  import tug_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 50
) (
  input logic          clk,
  input logic          reset,
  tug_referee_if.slave bus
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  winner_t            winner_q, winner_d;
  logic               pulse_l_q, pulse_l_d, pulse_r_q, pulse_r_d;
  logic               field_reset_q, game_over_q;
  logic               key_l_q;
  logic               rise_l, rise_r, valid_l, valid_r;

  assign rise_l = bus.key_l & ~key_l_q;

`ifdef CPU_PLAYER_EN
  logic [9:0] lfsr;
  logic       cpu_press_q;
  logic       unused_key_r;

  lfsr10 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  // The CPU press is self-masked so it can never fire on two consecutive cycles.
  assign rise_r       = (lfsr[2:0] < bus.difficulty) & ~cpu_press_q;
  assign unused_key_r = bus.key_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_press_q <= 1'b0;
    end else begin
      cpu_press_q <= rise_r;
    end
  end
`else
  logic key_r_q;
  logic unused_difficulty;

  assign rise_r            = bus.key_r & ~key_r_q;
  assign unused_difficulty = ^bus.difficulty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_r_q <= 1'b0;
    end else begin
      key_r_q <= bus.key_r;
    end
  end
`endif

  // Simultaneous presses cancel each other.
  assign valid_l = rise_l & ~rise_r;
  assign valid_r = rise_r & ~rise_l;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    pulse_l_d = 1'b0;
    pulse_r_d = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          state_d   = CLEAR;
          score_l_d = '0;
          score_r_d = '0;
        end
      end
      CLEAR: state_d = PLAY;
      PLAY: begin
        if (valid_l) begin
          if (bus.edge_l) begin
            if (score_l_q != WIN_VAL) score_l_d = score_l_q + 1'b1;
            winner_d = WIN_LEFT;
            state_d  = HOLD;
          end else begin
            pulse_l_d = 1'b1;
          end
        end
        if (valid_r) begin
          if (bus.edge_r) begin
            if (score_r_q != WIN_VAL) score_r_d = score_r_q + 1'b1;
            winner_d = WIN_RIGHT;
            state_d  = HOLD;
          end else begin
            pulse_r_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = ((score_l_q == WIN_VAL) || (score_r_q == WIN_VAL)) ? OVER : CLEAR;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == CLEAR) winner_d = WIN_NONE;
  end

  // Status outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      score_l_q     <= '0;
      score_r_q     <= '0;
      winner_q      <= WIN_NONE;
      pulse_l_q     <= 1'b0;
      pulse_r_q     <= 1'b0;
      field_reset_q <= 1'b1;
      game_over_q   <= 1'b0;
      key_l_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      winner_q      <= winner_d;
      pulse_l_q     <= pulse_l_d;
      pulse_r_q     <= pulse_r_d;
      field_reset_q <= (state_d == IDLE) || (state_d == CLEAR);
      game_over_q   <= (state_d == OVER);
      key_l_q       <= bus.key_l;
    end
  end

  assign bus.pulse_l     = pulse_l_q;
  assign bus.pulse_r     = pulse_r_q;
  assign bus.field_reset = field_reset_q;
  assign bus.score_l     = score_l_q;
  assign bus.score_r     = score_r_q;
  assign bus.winner      = winner_q;
  assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_tug_referee.sv
// Self-checking bench for tug_referee (WIN_SCORE=2, HOLD_CYCLES=3): vector table,
// directed corner sequences and random stimulus against a behavioural match model.
module tb_tug_referee;
  import tug_pkg::*;

  localparam int WIN  = 2;
  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tug_referee_if bus ();

  tug_referee #(
    .WIN_SCORE   (WIN),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: match phase, remembered key levels, scores and a hold countdown.
  typedef enum int {MIdle, MClear, MPlay, MHold, MOver} mphase_e;
  mphase_e m_phase;
  bit      m_kl, m_kr, m_pl, m_pr;
  int      m_sl, m_sr, m_win, m_hold;

  function automatic void model_reset();
    m_phase = MIdle;
    m_kl = 0; m_kr = 0; m_pl = 0; m_pr = 0;
    m_sl = 0; m_sr = 0; m_win = 0; m_hold = 0;
  endfunction

  function automatic void model_clock();
    bit rl, rr;
    rl = bus.key_l && !m_kl;
    rr = bus.key_r && !m_kr;
    if (rl && rr) begin
      rl = 0;
      rr = 0;
    end
    m_kl = bus.key_l;
    m_kr = bus.key_r;
    m_pl = 0;
    m_pr = 0;
    case (m_phase)
      MIdle, MOver: begin
        if (bus.start) begin
          m_sl = 0; m_sr = 0; m_win = 0;
          m_phase = MClear;
        end
      end
      MClear: m_phase = MPlay;
      MPlay: begin
        if (rl) begin
          if (bus.edge_l) begin
            m_sl++; m_win = 1; m_hold = HOLD; m_phase = MHold;
          end else m_pl = 1;
        end else if (rr) begin
          if (bus.edge_r) begin
            m_sr++; m_win = 2; m_hold = HOLD; m_phase = MHold;
          end else m_pr = 1;
        end
      end
      MHold: begin
        m_hold--;
        if (m_hold == 0) begin
          if (m_sl == WIN || m_sr == WIN) m_phase = MOver;
          else begin
            m_phase = MClear;
            m_win = 0;
          end
        end
      end
      default: m_phase = MIdle;
    endcase
  endfunction

  // Output word: {pulse_l, pulse_r, field_reset, score_l, score_r, winner, game_over}
  function automatic logic [11:0] pack_dut();
    return {bus.pulse_l, bus.pulse_r, bus.field_reset, bus.score_l, bus.score_r,
            bus.winner, bus.game_over};
  endfunction

  function automatic logic [11:0] pack_model();
    return {1'(m_pl), 1'(m_pr), 1'(m_phase == MIdle || m_phase == MClear), 3'(m_sl), 3'(m_sr),
            2'(m_win), 1'(m_phase == MOver)};
  endfunction

  function automatic logic [11:0] ex(input bit pl, input bit pr, input bit fr, input int sl,
                                     input int sr, input int w, input bit go);
    return {pl, pr, fr, 3'(sl), 3'(sr), 2'(w), go};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (pl pr fr sl sr w go)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input bit kl, input bit kr, input bit st, input bit el, input bit er);
    bus.key_l  = kl;
    bus.key_r  = kr;
    bus.start  = st;
    bus.edge_l = el;
    bus.edge_r = er;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic        kl, kr, st, el, er;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input bit kl, input bit kr, input bit st, input bit el,
                              input bit er, input logic [11:0] exp);
    vec_t v;
    v.kl = kl; v.kr = kr; v.st = st; v.el = el; v.er = er; v.exp = exp;
    return v;
  endfunction

  initial begin
    int pcount, first_pulse, consec;
    bit prev;
    bus.difficulty = 3'd0;
    do_reset();
    check("reset_state", pack_dut(), ex(0, 0, 1, 0, 0, 0, 0));

`ifdef CPU_PLAYER_EN
    set_in(0, 0, 1, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0);
    cycle();
    pcount = 0;
    for (int i = 0; i < 1000; i++) begin
      bus.key_r = 1'($urandom_range(0, 1));
      cycle();
      if (bus.pulse_r) pcount++;
    end
    check_int("cpu_diff0_pulses", pcount, 0);
    bus.difficulty = 3'd7;
    pcount = 0;
    consec = 0;
    prev = 0;
    for (int i = 0; i < 300; i++) begin
      bus.key_r = 1'($urandom_range(0, 1));
      cycle();
      if (bus.pulse_r) pcount++;
      if (bus.pulse_r && prev) consec++;
      prev = bus.pulse_r;
    end
    check_int("cpu_diff7_any", int'(pcount > 0), 1);
    check_int("cpu_diff7_consecutive", consec, 0);
    check_int("cpu_no_left_pulse", int'(bus.pulse_l), 0);
`else
    vecs[0]  = mk(0, 0, 1, 0, 0, ex(0, 0, 1, 0, 0, 0, 0));  // start -> CLEAR
    vecs[1]  = mk(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));  // PLAY
    vecs[2]  = mk(1, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0));
    vecs[3]  = mk(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));  // held key
    vecs[4]  = mk(0, 1, 0, 0, 0, ex(0, 1, 0, 0, 0, 0, 0));
    vecs[5]  = mk(1, 1, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0));  // only left rises
    vecs[6]  = mk(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    vecs[7]  = mk(1, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));  // tie
    vecs[8]  = mk(0, 0, 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));  // edge alone
    vecs[9]  = mk(1, 0, 0, 1, 0, ex(0, 0, 0, 1, 0, 1, 0));  // left round win
    vecs[10] = mk(0, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 1, 0));
    vecs[11] = mk(0, 0, 1, 0, 0, ex(0, 0, 0, 1, 0, 1, 0));  // start ignored in HOLD
    vecs[12] = mk(0, 0, 0, 0, 0, ex(0, 0, 1, 1, 0, 0, 0));  // CLEAR after 3 HOLD cycles
    vecs[13] = mk(0, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 0, 0));
    vecs[14] = mk(1, 0, 0, 1, 0, ex(0, 0, 0, 2, 0, 1, 0));
    vecs[15] = mk(0, 0, 0, 0, 0, ex(0, 0, 0, 2, 0, 1, 0));
    vecs[16] = mk(0, 0, 0, 0, 0, ex(0, 0, 0, 2, 0, 1, 0));
    vecs[17] = mk(0, 0, 0, 0, 0, ex(0, 0, 0, 2, 0, 1, 1));  // match over
    vecs[18] = mk(0, 1, 0, 0, 0, ex(0, 0, 0, 2, 0, 1, 1));
    vecs[19] = mk(1, 0, 0, 0, 0, ex(0, 0, 0, 2, 0, 1, 1));
    vecs[20] = mk(0, 0, 1, 0, 0, ex(0, 0, 1, 0, 0, 0, 0));  // restart
    vecs[21] = mk(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    vecs[22] = mk(0, 1, 0, 0, 1, ex(0, 0, 0, 0, 1, 2, 0));  // right round win

    for (int i = 0; i < 23; i++) begin
      set_in(vecs[i].kl, vecs[i].kr, vecs[i].st, vecs[i].el, vecs[i].er);
      cycle();
      check($sformatf("vec%0d", i), pack_dut(), vecs[i].exp);
    end

    // Held key: one pulse, in the cycle right after the first rising edge.
    do_reset();
    set_in(0, 0, 1, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0);
    cycle();
    pcount = 0;
    first_pulse = -1;
    bus.key_l = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (bus.pulse_l) begin
        pcount++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    check_int("held_key_count", pcount, 1);
    check_int("held_key_latency", first_pulse, 0);

    // Asynchronous reset between edges while in HOLD.
    set_in(0, 0, 0, 0, 0);
    cycle();
    set_in(1, 0, 0, 1, 0);
    cycle();
    check("enter_hold", pack_dut(), ex(0, 0, 0, 1, 0, 1, 0));
    set_in(0, 0, 0, 0, 0);
    cycle();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_now", pack_dut(), ex(0, 0, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("async_reset_hold", pack_dut(), ex(0, 0, 1, 0, 0, 0, 0));

    // Random play against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      cycle();
      check($sformatf("rand%0d", i), pack_dut(), pack_model());
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tug_referee.md
# tug_referee

Round and match controller for the tug-of-war playfield. It turns raw player keys into one-cycle press pulses for the light chain. It decides round wins from the playfield edge lights, keeps per-player scores, holds the playfield in reset between rounds, and declares the match winner. It sits between the board keys/start switch and the row of center/normal light cells, and drives the score displays.

## Interface
Parameters:
- WIN_SCORE, 7: round wins needed to take the match; legal range 1..7.
- HOLD_CYCLES, 50: cycles the round result is frozen before the next round; legal range ≥1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_l  in  1  left key level, already synchronized to clk.
- key_r  in  1  right key level, already synchronized; ignored when CPU_PLAYER_EN is defined.
- start  in  1  level; begins a match from IDLE or OVER.
- edge_l  in  1  leftmost playfield light is on.
- edge_r  in  1  rightmost playfield light is on.
- difficulty  in  3  CPU aggressiveness; used only with CPU_PLAYER_EN.
- pulse_l  out  1  one-cycle left press to the playfield.
- pulse_r  out  1  one-cycle right press to the playfield.
- field_reset  out  1  active-high reset to the playfield cells.
- score_l  out  3  left round wins.
- score_r  out  3  right round wins.
- winner  out  2  00 none, 01 left, 10 right; last round or match winner.
- game_over  out  1  match finished.

## Operation
- Press detect: key_l_q/key_r_q registers. rise_x = key_x & ~key_x_q. If rise_l and rise_r occur in the same cycle, both are discarded, so a tie forwards nothing.
- FSM states: IDLE, CLEAR, PLAY, HOLD, OVER.
- IDLE:
  - field_reset=1; pulses 0.
  - start=1 → CLEAR, and both scores are cleared to 0.
- CLEAR:
  - field_reset=1 for exactly one cycle; winner←00.
  - Always → PLAY.
- PLAY:
  - field_reset=0.
  - A valid rise_x with edge_x=0 produces pulse_x=1 for the next cycle.
  - A valid rise_l with edge_l=1 is a left round win: no pulse is issued, score_l+1, winner←01, → HOLD. The right side is symmetric, with winner←10.
  - edge_x without a press has no effect.
- HOLD:
  - Pulses are suppressed and field_reset=0, so the winning light stays visible.
  - A counter runs HOLD_CYCLES cycles.
  - Then: if either score equals WIN_SCORE → OVER, else → CLEAR.
- OVER:
  - game_over=1; winner and scores are held; pulses 0.
  - start=1 → CLEAR, and scores are cleared.
- Scores: 3-bit unsigned. They never exceed WIN_SCORE and never wrap.
- start while in CLEAR, PLAY or HOLD is ignored.

## Timing
- Reset values: state IDLE, field_reset=1, pulse_l=pulse_r=0, score_l=score_r=0, winner=00, game_over=0, hold counter 0, key registers 0.
- All outputs are registered.
- Press latency: key rises before edge k, so pulse_x is high for exactly the cycle after edge k. A held key yields one pulse only.
- Round win: score, winner and the HOLD entry all become visible in the cycle after the winning edge.
- HOLD lasts exactly HOLD_CYCLES cycles. field_reset then asserts for one cycle in CLEAR, and PLAY starts on the following cycle.
- Reset asserted mid-match forces IDLE immediately, without waiting for clk. Scores clear and field_reset asserts.

## Configuration
- CPU_PLAYER_EN defined:
  - The right player is a computer and key_r is unused.
  - A 10-bit LFSR (XNOR taps 10,7; reset value 0) advances every cycle.
  - cpu_press = (lfsr[2:0] < difficulty) & ~cpu_press_q. This replaces rise_r, so the CPU never presses two cycles in a row.
  - difficulty=0 means the CPU never presses.
- CPU_PLAYER_EN undefined:
  - The right player uses key_r.
  - difficulty is ignored and no LFSR is instantiated.

## Structure
- Shared package tug_pkg holds:
  - state enum typedef (IDLE, CLEAR, PLAY, HOLD, OVER);
  - winner encoding constants WIN_NONE/WIN_LEFT/WIN_RIGHT;
  - SCORE_W=3.
- Sub-module lfsr10 (clk, reset, q[9:0]) exists and is instantiated only under CPU_PLAYER_EN.

## Test plan
- Reset then idle: outputs are field_reset=1, scores 0, winner 00. Assert start → one CLEAR cycle, then field_reset=0.
- Press forwarding: key_l held high for 5 cycles in PLAY, edges low → exactly one pulse_l, in the cycle after the first rising edge. key_l and key_r rising together → no pulse.
- Round win: in PLAY with edge_r=1, key_r rises → no pulse_r; next cycle score_r=1, winner=10. field_reset then asserts after exactly HOLD_CYCLES cycles.
- Match end with WIN_SCORE=2, HOLD_CYCLES=3: two left round wins → game_over=1, winner=01, score_l=2. Further key presses give no pulses; start → scores 0 and CLEAR.
- Async reset asserted mid-HOLD between clock edges → IDLE immediately, scores 0, field_reset=1.
- With CPU_PLAYER_EN: difficulty=0 → no pulse_r over 1000 cycles. difficulty=7 → pulse_r appears, never in consecutive cycles, and key_r toggling has no effect.
